// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
//   Shared types and constants for the clock-divider sequencer.
//   - state_e   : sequencer states (IDLE / RUN / DRAIN)
//   - CNT_W_DEF : default ratio/count width
//   - BURST_W_DEF : default period-count width
//   - MIN_RATIO : smallest legal divide ratio
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W_DEF   = 4;
  localparam int BURST_W_DEF = 8;
  localparam int MIN_RATIO   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/mod_n_counter.sv
// ---------------------------------------------------------------------------
// mod_n_counter
//   Phase counter 0..N-1 with a wrap flag on the last phase. A new ratio can
//   be loaded at any time; it is adopted on the wrap edge, or immediately
//   while the counter is disabled, so a running period is never cut short.
// Ports
//   clk      in   clock
//   i_clear  in   synchronous clear (count=0, ratio=MIN_RATIO)
//   i_en     in   advance the count
//   i_load   in   load-ratio strobe
//   i_ratio  in   ratio to load (CNT_W)
//   o_count  out  current phase (CNT_W)
//   o_wrap   out  enabled and on the last phase of the period
// ---------------------------------------------------------------------------
module mod_n_counter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_ratio,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_ratio;
  logic [CNT_W-1:0] w_last_val;

  assign w_last_val = r_ratio - CNT_W'(1);
  assign o_wrap     = i_en & (r_count == w_last_val);
  assign o_count    = r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
      r_ratio <= CNT_W'(MIN_RATIO);
    end else begin
      if (i_en) r_count <= o_wrap ? '0 : r_count + CNT_W'(1);
      if (i_load && (o_wrap || !i_en)) r_ratio <= i_ratio;
    end
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// ---------------------------------------------------------------------------
// clk_div_sequencer
//   Accepts divide-ratio/burst configs over valid/ready and runs a mod-N
//   divider for a number of periods (or free-running), producing a
//   near-50% divided level and a period-start tick. One config may be
//   queued while running; it takes over exactly at the next period boundary.
// Ports
//   clk          in   clock, all logic on posedge
//   reset_L      in   synchronous active-low reset
//   cfg_valid    in   config offered
//   cfg_ready    out  config can be taken
//   cfg_ratio    in   divide ratio N (CNT_W)
//   cfg_periods  in   periods to run, 0 = until stop (BURST_W)
//   stop         in   finish current period, then idle
//   div_out      out  high for ceil(N/2) of every N cycles
//   div_tick     out  pulse on phase 0 of each period
//   count_out    out  current phase (CNT_W)
//   busy         out  RUN or DRAIN
//   done         out  pulse in first IDLE cycle after a burst/stop
//   cfg_err      out  pulse after an accepted config with ratio < 2
// ---------------------------------------------------------------------------
module clk_div_sequencer
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_ratio,
  input  logic [BURST_W-1:0] cfg_periods,
  input  logic               stop,
  output logic               div_out,
  output logic               div_tick,
  output logic [CNT_W-1:0]   count_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  state_e             r_state, w_next_state;
  logic               r_pend_valid;
  logic [CNT_W-1:0]   r_pend_ratio;
  logic [BURST_W-1:0] r_pend_periods;
  logic [BURST_W-1:0] r_remaining;
  logic [CNT_W:0]     r_hi_len;
  logic               r_done;
  logic               r_cfg_err;

  logic               w_busy, w_accept, w_legal, w_wrap;
  logic               w_start, w_apply_pend, w_finish;
  logic [CNT_W-1:0]   w_count, w_load_ratio;
  logic [CNT_W:0]     w_hi_len;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = cfg_valid & cfg_ready;
  assign w_legal  = (cfg_ratio >= CNT_W'(MIN_RATIO));
  assign w_start  = (r_state == ST_IDLE) & w_accept & w_legal;

  // Queued config takes over at the wrap unless stop is draining the run.
  assign w_apply_pend = (r_state == ST_RUN) & w_wrap & r_pend_valid & ~stop;

  // Run ends at this wrap: DRAIN always; RUN when the last period closes and
  // nothing queued survives (stop discards the queued config).
  assign w_finish = w_wrap & ((r_state == ST_DRAIN) |
                    ((r_state == ST_RUN) & (r_remaining == BURST_W'(1)) &
                     (stop | ~r_pend_valid)));

  assign w_load_ratio = w_start ? cfg_ratio : r_pend_ratio;
  // Extra bit keeps (N+1) from overflowing at N = 2**CNT_W-1.
  assign w_hi_len     = ({1'b0, w_load_ratio} + (CNT_W+1)'(1)) >> 1;

  mod_n_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .i_clear (~reset_L),
    .i_en    (w_busy),
    .i_load  (w_start | w_apply_pend),
    .i_ratio (w_load_ratio),
    .o_count (w_count),
    .o_wrap  (w_wrap)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_L) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // (which would infer a latch).
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start) w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_finish)  w_next_state = ST_IDLE;
        else if (stop) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: if (w_finish) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output decode: registered state and count only, plus stop for backpressure
  always_comb begin
    busy      = w_busy;
    count_out = w_count;
    div_tick  = w_busy & (w_count == '0);
    div_out   = w_busy & ({1'b0, w_count} < r_hi_len);
    done      = r_done;
    cfg_err   = r_cfg_err;
    unique case (r_state)
      ST_IDLE: cfg_ready = 1'b1;
      ST_RUN:  cfg_ready = ~r_pend_valid & ~stop;
      default: cfg_ready = 1'b0;
    endcase
  end

  // Burst bookkeeping, pending slot and status pulses
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_pend_valid   <= 1'b0;
      r_pend_ratio   <= '0;
      r_pend_periods <= '0;
      r_remaining    <= '0;
      r_hi_len       <= '0;
      r_done         <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_done    <= w_finish;
      r_cfg_err <= w_accept & ~w_legal;

      if (w_start) begin
        r_remaining <= cfg_periods;
        r_hi_len    <= w_hi_len;
      end else if (w_apply_pend) begin
        r_remaining <= r_pend_periods;
        r_hi_len    <= w_hi_len;
      end else if (w_busy && w_wrap && r_remaining != '0) begin
        // Zero means free-run and is never decremented.
        r_remaining <= r_remaining - BURST_W'(1);
      end

      if (((r_state == ST_RUN) && stop) || w_apply_pend) begin
        r_pend_valid <= 1'b0;
      end else if ((r_state == ST_RUN) && w_accept && w_legal) begin
        r_pend_valid   <= 1'b1;
        r_pend_ratio   <= cfg_ratio;
        r_pend_periods <= cfg_periods;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_sequencer.sv
module tb_clk_div_sequencer;

  localparam int CNT_W   = 4;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               reset_L;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_ratio;
  logic [BURST_W-1:0] cfg_periods;
  logic               stop;
  logic               div_out;
  logic               div_tick;
  logic [CNT_W-1:0]   count_out;
  logic               busy;
  logic               done;
  logic               cfg_err;

  always #5 clk = ~clk;

  clk_div_sequencer #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ratio   (cfg_ratio),
    .cfg_periods (cfg_periods),
    .stop        (stop),
    .div_out     (div_out),
    .div_tick    (div_tick),
    .count_out   (count_out),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A burst is described by its ratio, its period budget and the number of
  // cycles elapsed since it began; phase and period index follow by division.
  bit m_ok = 0;
  bit m_busy, m_drain, m_done, m_err;
  int m_n, m_periods, m_t;
  int m_q_ratio[$];
  int m_q_per[$];

  function automatic int m_phase();
    return m_busy ? (m_t % m_n) : 0;
  endfunction

  function automatic bit m_ready(input bit s);
    if (!m_busy) return 1'b1;
    return !m_drain && (m_q_ratio.size() == 0) && !s;
  endfunction

  function automatic void m_finish();
    m_busy  = 0;
    m_drain = 0;
    m_done  = 1;
    m_t     = 0;
  endfunction

  function automatic void model_step();
    int  ph;
    bit  acc, legal, last, end_burst, had_pend;
    if (!reset_L) begin
      m_busy = 0; m_drain = 0; m_done = 0; m_err = 0; m_t = 0; m_n = 2;
      m_q_ratio.delete(); m_q_per.delete();
      m_ok = 1;
      return;
    end
    if (!m_ok) return;
    ph    = m_phase();
    acc   = cfg_valid && m_ready(stop);
    legal = (int'(cfg_ratio) >= 2);
    m_done = 0;
    m_err  = 0;
    if (!m_busy) begin
      if (acc) begin
        if (legal) begin
          m_busy = 1; m_drain = 0; m_n = int'(cfg_ratio);
          m_periods = int'(cfg_periods); m_t = 0;
        end else m_err = 1;
      end
    end else begin
      last      = (ph == m_n - 1);
      end_burst = last && (m_periods != 0) && (m_t / m_n + 1 == m_periods);
      if (m_drain) begin
        if (last) m_finish(); else m_t++;
      end else if (stop) begin
        m_q_ratio.delete(); m_q_per.delete();
        if (end_burst) m_finish();
        else begin m_drain = 1; m_t++; end
      end else begin
        had_pend = (m_q_ratio.size() != 0);
        if (acc) begin
          if (legal) begin
            m_q_ratio.push_back(int'(cfg_ratio));
            m_q_per.push_back(int'(cfg_periods));
          end else m_err = 1;
        end
        if (last && had_pend) begin
          m_n = m_q_ratio.pop_front();
          m_periods = m_q_per.pop_front();
          m_t = 0;
        end else if (end_burst) m_finish();
        else m_t++;
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare every cycle once reset has been applied
  initial forever begin
    int ph;
    @(negedge clk);
    if (m_ok) begin
      ph = m_phase();
      check("m_count",  32'(count_out), 32'(ph));
      check("m_busy",   32'(busy),      32'(m_busy));
      check("m_div",    32'(div_out),   32'(m_busy && (ph < (m_n + 1) / 2)));
      check("m_tick",   32'(div_tick),  32'(m_busy && ph == 0));
      check("m_done",   32'(done),      32'(m_done));
      check("m_err",    32'(cfg_err),   32'(m_err));
      check("m_ready",  32'(cfg_ready), 32'(m_ready(stop)));
    end
  end

  // ---------------- directed stimulus ----------------
  // After step() we are mid-cycle: outputs of this cycle are stable, and any
  // input driven now is sampled at the edge that ends this cycle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(input int r, input int p);
    cfg_valid   = 1'b1;
    cfg_ratio   = CNT_W'(r);
    cfg_periods = BURST_W'(p);
  endtask

  int exp_cnt1[6] = '{0, 1, 2, 0, 1, 2};
  int exp_div1[6] = '{1, 1, 0, 1, 1, 0};
  int exp_div6[6] = '{1, 1, 1, 0, 0, 0};
  int exp_div_b2b[5] = '{1, 0, 1, 1, 0};

  initial begin
    reset_L = 1'b0; cfg_valid = 1'b0; cfg_ratio = '0; cfg_periods = '0; stop = 1'b0;
    step(); step();
    reset_L = 1'b1;
    step();
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_div",   32'(div_out),   32'd0);

    // 1: ratio 3, two periods
    offer(3, 2);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t1_count", 32'(count_out), 32'(exp_cnt1[i]));
      check("t1_div",   32'(div_out),   32'(exp_div1[i]));
      check("t1_tick",  32'(div_tick),  32'(i % 3 == 0));
      cfg_valid = 1'b0;
    end
    step();
    check("t1_done", 32'(done), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    step();
    check("t1_done_once", 32'(done), 32'd0);

    // 2: ratio 4 free-run, queue ratio 6 (cycle 0 = accept cycle)
    offer(4, 0);
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) cfg_valid = 1'b0;
      if (c == 5) begin
        check("t2_ready_c5", 32'(cfg_ready), 32'd1);
        offer(6, 0);
      end
      if (c == 6) cfg_valid = 1'b0;
      if (c >= 6 && c <= 8) check("t2_ready_low", 32'(cfg_ready), 32'd0);
      if (c >= 9) check("t2_div6", 32'(div_out), 32'(exp_div6[c-9]));
      if (c == 9) begin
        check("t2_ready_c9", 32'(cfg_ready), 32'd1);
        stop = 1'b1;
      end
      if (c == 10) stop = 1'b0;
    end
    step();
    check("t2_done", 32'(done), 32'd1);

    // 3: ratio 5 free-run, queued cfg then stop at count 1
    offer(5, 0);
    step();                       // count 0
    offer(3, 0);                  // fills the pending slot
    step();                       // count 1
    check("t3_ready_full", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    stop = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      step();
      stop = 1'b0;
      check("t3_drain_cnt", 32'(count_out), 32'(c));
      check("t3_drain_rdy", 32'(cfg_ready), 32'd0);
      offer(9, 0);                // offered in DRAIN, must be ignored
      if (c == 4) cfg_valid = 1'b0;
    end
    step();
    check("t3_done", 32'(done), 32'd1);
    check("t3_idle", 32'(busy), 32'd0);
    step();
    check("t3_done_once", 32'(done), 32'd0);
    check("t3_no_pend",   32'(busy), 32'd0);

    // 4: illegal ratios
    offer(1, 3);
    step();
    cfg_valid = 1'b0;
    check("t4_err_idle",  32'(cfg_err), 32'd1);
    check("t4_busy_idle", 32'(busy),    32'd0);
    step();
    check("t4_err_clear", 32'(cfg_err), 32'd0);
    offer(4, 0);
    step();                       // count 0
    cfg_valid = 1'b0;
    step();                       // count 1
    offer(0, 5);
    step();                       // count 2
    cfg_valid = 1'b0;
    check("t4_err_run",   32'(cfg_err),   32'd1);
    check("t4_rdy_run",   32'(cfg_ready), 32'd1);
    check("t4_cnt_run",   32'(count_out), 32'd2);
    step(); step();               // count 3, count 0
    check("t4_unchanged", 32'(div_tick),  32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step(); step(); step();
    check("t4_done", 32'(done), 32'd1);

    // 5: reset mid-period
    offer(7, 0);
    step();
    cfg_valid = 1'b0;
    step(); step();
    check("t5_cnt2", 32'(count_out), 32'd2);
    reset_L = 1'b0;
    step();
    check("t5_cnt",   32'(count_out), 32'd0);
    check("t5_busy",  32'(busy),      32'd0);
    check("t5_div",   32'(div_out),   32'd0);
    check("t5_done",  32'(done),      32'd0);
    check("t5_ready", 32'(cfg_ready), 32'd1);
    reset_L = 1'b1;
    step();
    check("t5_no_done", 32'(done), 32'd0);

    // 6: back-to-back bursts, no idle gap
    offer(2, 1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("t6_div",  32'(div_out), 32'(exp_div_b2b[c]));
      check("t6_busy", 32'(busy),    32'd1);
      check("t6_done", 32'(done),    32'd0);
      if (c == 2) check("t6_tick2", 32'(div_tick), 32'd1);
      if (c == 0) offer(3, 1);
      else cfg_valid = 1'b0;
    end
    step();
    check("t6_end_done", 32'(done), 32'd1);
    check("t6_end_idle", 32'(busy), 32'd0);

    // 7: largest ratio, one period (hi_len = 8)
    offer(15, 1);
    for (int c = 0; c < 15; c++) begin
      step();
      cfg_valid = 1'b0;
      check("t7_div", 32'(div_out), 32'(c < 8));
    end
    step();
    check("t7_done", 32'(done), 32'd1);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
